// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pipe
// Description : Decode stage with bypassed register file, load-use hazard
//               detection and a stallable/flushable ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_pipe #(
    parameter int DATA_W      = 16,
    parameter int INSTR_W     = 16,
    parameter int NUM_REGS    = 8,
    parameter int CTRL_W      = 24,
    parameter int MEMREAD_BIT = 2,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_imm,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              stall_if,
    output logic              id_valid,
    output logic [CTRL_W-1:0] id_ctrl,
    output logic [DATA_W-1:0] id_rs1_val,
    output logic [DATA_W-1:0] id_rs2_val,
    output logic [DATA_W-1:0] id_imm,
    output logic [AW-1:0]     id_rs1,
    output logic [AW-1:0]     id_rs2,
    output logic [AW-1:0]     id_rdst
);

    localparam int c_RS1_MSB = INSTR_W - 6;
    localparam int c_RS2_MSB = INSTR_W - 6 - AW;

    logic [DATA_W-1:0] r_regs_q [NUM_REGS];
    logic [DATA_W-1:0] w_regs_d [NUM_REGS];

    logic              r_valid_q, w_valid_d;
    logic [CTRL_W-1:0] r_ctrl_q,  w_ctrl_d;
    logic [DATA_W-1:0] r_rs1v_q,  w_rs1v_d;
    logic [DATA_W-1:0] r_rs2v_q,  w_rs2v_d;
    logic [DATA_W-1:0] r_imm_q,   w_imm_d;
    logic [AW-1:0]     r_rs1_q,   w_rs1_d;
    logic [AW-1:0]     r_rs2_q,   w_rs2_d;

    logic [AW-1:0]     w_rs1;
    logic [AW-1:0]     w_rs2;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic              w_luh;
    logic              w_unused_instr;

    assign w_rs1 = if_instr[c_RS1_MSB -: AW];
    assign w_rs2 = if_instr[c_RS2_MSB -: AW];
    // Opcode is consumed by the external control unit, not here.
    assign w_unused_instr = ^{if_instr[INSTR_W-1:INSTR_W-5], if_instr[c_RS2_MSB-AW:0]};

    // Write-through: a same-cycle writeback is visible to the decoding instruction.
    assign w_rdata1 = (wb_en && (wb_addr == w_rs1)) ? wb_data : r_regs_q[w_rs1];
    assign w_rdata2 = (wb_en && (wb_addr == w_rs2)) ? wb_data : r_regs_q[w_rs2];

    // Destination equals rs1 in this two-address ISA.
    assign w_luh = if_valid & r_valid_q & r_ctrl_q[MEMREAD_BIT]
                 & ((r_rs1_q == w_rs1) | (r_rs1_q == w_rs2));

    assign stall_if = ex_stall | (w_luh & ~flush);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_regs_d[i] = r_regs_q[i];
        end
        if (wb_en) begin
            w_regs_d[wb_addr] = wb_data;
        end
    end

    always_comb begin
        w_valid_d = r_valid_q;
        w_ctrl_d  = r_ctrl_q;
        w_rs1v_d  = r_rs1v_q;
        w_rs2v_d  = r_rs2v_q;
        w_imm_d   = r_imm_q;
        w_rs1_d   = r_rs1_q;
        w_rs2_d   = r_rs2_q;
        if (flush) begin
            w_valid_d = 1'b0;
            w_ctrl_d  = '0;
            w_rs1v_d  = '0;
            w_rs2v_d  = '0;
            w_imm_d   = '0;
            w_rs1_d   = '0;
            w_rs2_d   = '0;
        end else if (ex_stall) begin
            w_valid_d = r_valid_q;
        end else if (w_luh) begin
            // Bubble; the instruction is re-decoded next cycle with fresh reads.
            w_valid_d = 1'b0;
            w_ctrl_d  = '0;
        end else begin
            w_valid_d = if_valid;
            w_ctrl_d  = if_valid ? ctrl_in : '0;
            w_rs1v_d  = w_rdata1;
            w_rs2v_d  = w_rdata2;
            w_imm_d   = if_imm;
            w_rs1_d   = w_rs1;
            w_rs2_d   = w_rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs_q[i] <= '0;
            end
            r_valid_q <= 1'b0;
            r_ctrl_q  <= '0;
            r_rs1v_q  <= '0;
            r_rs2v_q  <= '0;
            r_imm_q   <= '0;
            r_rs1_q   <= '0;
            r_rs2_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs_q[i] <= w_regs_d[i];
            end
            r_valid_q <= w_valid_d;
            r_ctrl_q  <= w_ctrl_d;
            r_rs1v_q  <= w_rs1v_d;
            r_rs2v_q  <= w_rs2v_d;
            r_imm_q   <= w_imm_d;
            r_rs1_q   <= w_rs1_d;
            r_rs2_q   <= w_rs2_d;
        end
    end

    assign id_valid   = r_valid_q;
    assign id_ctrl    = r_ctrl_q;
    assign id_rs1_val = r_rs1v_q;
    assign id_rs2_val = r_rs2v_q;
    assign id_imm     = r_imm_q;
    assign id_rs1     = r_rs1_q;
    assign id_rs2     = r_rs2_q;
    assign id_rdst    = r_rs1_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage_pipe
// Description : Directed self-checking bench for decode_stage_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_pipe;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_imm;
    logic [23:0] ctrl_in;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ex_stall;
    logic        flush;
    logic        stall_if;
    logic        id_valid;
    logic [23:0] id_ctrl;
    logic [15:0] id_rs1_val;
    logic [15:0] id_rs2_val;
    logic [15:0] id_imm;
    logic [2:0]  id_rs1;
    logic [2:0]  id_rs2;
    logic [2:0]  id_rdst;

    int total;
    int bad;

    decode_stage_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_imm     (if_imm),
        .ctrl_in    (ctrl_in),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_stall   (ex_stall),
        .flush      (flush),
        .stall_if   (stall_if),
        .id_valid   (id_valid),
        .id_ctrl    (id_ctrl),
        .id_rs1_val (id_rs1_val),
        .id_rs2_val (id_rs2_val),
        .id_imm     (id_imm),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rdst    (id_rdst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rs1,
                                       input logic [2:0] rs2);
        return {op, rs1, rs2, 5'b00000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0; if_instr = '0; if_imm = '0; ctrl_in = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        total++; if (id_ctrl !== 24'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=000000", id_ctrl); end
        total++; if ({id_rs1_val, id_rs2_val, id_imm} !== 48'h0) begin bad++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", id_rs1_val, id_rs2_val, id_imm); end
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_if); end
        reset = 1'b0;
    endtask

    task automatic test_read();
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
        tick();
        wb_en = 1'b0;
        if_valid = 1'b1; if_instr = mk(5'h01, 3'd3, 3'd0); if_imm = 16'h00AA; ctrl_in = 24'h000011;
        tick();
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL read_valid got=%b exp=1", id_valid); end
        total++; if (id_ctrl !== 24'h000011) begin bad++; $display("FAIL read_ctrl got=%h exp=000011", id_ctrl); end
        total++; if (id_rs1_val !== 16'h1234) begin bad++; $display("FAIL read_rs1 got=%h exp=1234", id_rs1_val); end
        total++; if (id_rs2_val !== 16'h0000) begin bad++; $display("FAIL read_rs2 got=%h exp=0000", id_rs2_val); end
        total++; if (id_imm !== 16'h00AA) begin bad++; $display("FAIL read_imm got=%h exp=00aa", id_imm); end
        total++; if ({id_rs1, id_rs2, id_rdst} !== {3'd3, 3'd0, 3'd3}) begin bad++;
            $display("FAIL read_idx got=%0d/%0d/%0d exp=3/0/3", id_rs1, id_rs2, id_rdst); end
        if_valid = 1'b0; ctrl_in = '0;
        tick();
        total++; if (id_valid !== 1'b0 || id_ctrl !== 24'h0) begin bad++;
            $display("FAIL idle_capture got=%b/%h exp=0/000000", id_valid, id_ctrl); end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF;
        if_valid = 1'b1; if_instr = mk(5'h02, 3'd5, 3'd5); if_imm = 16'h0001; ctrl_in = 24'h000100;
        tick();
        wb_en = 1'b0;
        total++; if (id_rs1_val !== 16'hBEEF) begin bad++; $display("FAIL bypass_rs1 got=%h exp=beef", id_rs1_val); end
        total++; if (id_rs2_val !== 16'hBEEF) begin bad++; $display("FAIL bypass_rs2 got=%h exp=beef", id_rs2_val); end
    endtask

    task automatic test_load_use();
        if_valid = 1'b1; if_instr = mk(5'h03, 3'd2, 3'd0); ctrl_in = 24'h000004; if_imm = 16'h0002;
        tick();
        if_instr = mk(5'h04, 3'd6, 3'd2); ctrl_in = 24'h000030; if_imm = 16'h0055;
        #1;
        total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall_if); end
        tick();
        total++; if (id_valid !== 1'b0 || id_ctrl !== 24'h0) begin bad++;
            $display("FAIL lu_bubble got=%b/%h exp=0/000000", id_valid, id_ctrl); end
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", stall_if); end
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h7777;
        tick();
        wb_en = 1'b0;
        total++; if (id_valid !== 1'b1 || id_ctrl !== 24'h000030) begin bad++;
            $display("FAIL lu_enter got=%b/%h exp=1/000030", id_valid, id_ctrl); end
        total++; if (id_rs2_val !== 16'h7777 || id_rs1_val !== 16'h0000) begin bad++;
            $display("FAIL lu_fresh got=%h/%h exp=0000/7777", id_rs1_val, id_rs2_val); end
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL lu_after got=%b exp=0", stall_if); end
    endtask

    task automatic test_ex_stall();
        logic [15:0] seq [3];
        seq[0] = 16'h6601; seq[1] = 16'h6602; seq[2] = 16'h6666;
        ex_stall = 1'b1;
        if_valid = 1'b1; if_instr = mk(5'h05, 3'd1, 3'd4); ctrl_in = 24'h000200; if_imm = 16'h0099;
        for (int k = 0; k < 3; k++) begin
            wb_en = 1'b1; wb_addr = 3'd6; wb_data = seq[k];
            #1;
            total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL stall_if_%0d got=%b exp=1", k, stall_if); end
            tick();
            total++; if (id_valid !== 1'b1 || id_ctrl !== 24'h000030 || id_rs1_val !== 16'h0000 ||
                         id_rs2_val !== 16'h7777 || id_imm !== 16'h0055 || id_rdst !== 3'd6) begin bad++;
                $display("FAIL stall_hold_%0d got=%b/%h/%h/%h/%h/%0d exp=1/000030/0000/7777/0055/6",
                         k, id_valid, id_ctrl, id_rs1_val, id_rs2_val, id_imm, id_rdst); end
        end
        ex_stall = 1'b0; wb_en = 1'b0;
        if_instr = mk(5'h06, 3'd6, 3'd0); ctrl_in = 24'h000041;
        tick();
        total++; if (id_rs1_val !== 16'h6666 || id_ctrl !== 24'h000041) begin bad++;
            $display("FAIL stall_resume got=%h/%h exp=6666/000041", id_rs1_val, id_ctrl); end
    endtask

    task automatic test_flush_stall();
        if_valid = 1'b1; if_instr = mk(5'h07, 3'd4, 3'd1); ctrl_in = 24'h000004;
        tick();
        if_instr = mk(5'h08, 3'd4, 3'd3); ctrl_in = 24'h000800;
        ex_stall = 1'b1; flush = 1'b1;
        #1;
        total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL flush_stall_if got=%b exp=1", stall_if); end
        tick();
        total++; if (id_valid !== 1'b0 || id_ctrl !== 24'h0) begin bad++;
            $display("FAIL flush_kill got=%b/%h exp=0/000000", id_valid, id_ctrl); end
        total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL flush_exstall got=%b exp=1", stall_if); end
        ex_stall = 1'b0; flush = 1'b0;
        #1;
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL flush_release got=%b exp=0", stall_if); end
    endtask

    task automatic test_reset_mid_bubble();
        if_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h1111;
        tick();
        wb_addr = 3'd7; wb_data = 16'h7007;
        tick();
        wb_en = 1'b0;
        if_valid = 1'b1; if_instr = mk(5'h09, 3'd1, 3'd0); ctrl_in = 24'h000004;
        tick();
        total++; if (id_rs1_val !== 16'h1111) begin bad++; $display("FAIL preload got=%h exp=1111", id_rs1_val); end
        if_instr = mk(5'h0A, 3'd1, 3'd7); ctrl_in = 24'h000008;
        #1;
        total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL rst_luh got=%b exp=1", stall_if); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (id_valid !== 1'b0 || id_ctrl !== 24'h0 || id_rs1_val !== 16'h0 || id_rs2_val !== 16'h0 ||
                     id_imm !== 16'h0 || {id_rs1, id_rs2, id_rdst} !== 9'h0) begin bad++;
            $display("FAIL rst_clear got=%b/%h/%h/%h/%h exp=all zero",
                     id_valid, id_ctrl, id_rs1_val, id_rs2_val, id_imm); end
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall_if); end
        tick();
        total++; if (id_valid !== 1'b1 || id_rs1_val !== 16'h0 || id_rs2_val !== 16'h0) begin bad++;
            $display("FAIL rst_regs17 got=%b/%h/%h exp=1/0000/0000", id_valid, id_rs1_val, id_rs2_val); end
        if_instr = mk(5'h0B, 3'd3, 3'd5); ctrl_in = 24'h000010;
        tick();
        total++; if (id_rs1_val !== 16'h0 || id_rs2_val !== 16'h0) begin bad++;
            $display("FAIL rst_regs35 got=%h/%h exp=0000/0000", id_rs1_val, id_rs2_val); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_read();
        test_bypass();
        test_load_use();
        test_ex_stall();
        test_flush_stall();
        test_reset_mid_bubble();
        idle();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
